// File: rtl/moldudp64_pkg.sv
// Shared constants and types for the MoldUDP64 message splitter.
package moldudp64_pkg;
  localparam int LEN_W          = 16;
  localparam int MOLD_LEN_BYTES = 2;
  localparam int DEF_KEEP_W     = 8;
  localparam int DEF_KEEP_LW    = $clog2(DEF_KEEP_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN_ALIGN,
    ST_LEN_SPLIT,
    ST_MSG
  } state_e;

  typedef logic [DEF_KEEP_LW-1:0] byte_off_t;
  typedef logic [DEF_KEEP_LW-1:0] byte_cnt_t;
endpackage

// File: rtl/cnt_ones_thermo.sv
// Counts set bits of a thermometer byte-enable vector.
module cnt_ones_thermo #(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  thermo_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(thermo_i[i]);
  end
endmodule

// File: rtl/msg_frag_align.sv
// Shifts a fragment down to byte 0 and zeroes bytes past its length.
module msg_frag_align #(
  parameter int DATA_W  = 64,
  parameter int KEEP_LW = 4
) (
  input  logic [DATA_W-1:0]  data_i,
  input  logic [KEEP_LW-1:0] off_i,
  input  logic [KEEP_LW-1:0] len_i,
  output logic [DATA_W-1:0]  data_o,
  output logic [KEEP_LW-1:0] len_o
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = data_i >> {off_i, 3'b000};
    data_o  = '0;
    for (int b = 0; b < NB; b++)
      if (KEEP_LW'(b) < len_i) data_o[b*8 +: 8] = shifted[b*8 +: 8];
  end

  assign len_o = len_i;
endmodule

// File: rtl/moldudp64_msg_splitter.sv
// Splits MoldUDP64 message blocks into per-lane, byte-0 aligned fragments.
// Optional completed-message counter: define MOLD_MSG_CNT_EN.
module moldudp64_msg_splitter
  import moldudp64_pkg::*;
#(
  parameter int AXI_DATA_W = 64,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int KEEP_LW    = $clog2(AXI_KEEP_W) + 1,
  parameter int OUT        = 2
`ifdef MOLD_MSG_CNT_EN
  , parameter int MSG_CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    valid_i,
  input  logic [AXI_DATA_W-1:0]   data_i,
  input  logic [AXI_KEEP_W-1:0]   keep_i,
  input  logic                    init_v_i,
  input  logic [KEEP_LW-1:0]      init_off_i,
  input  logic                    last_i,
  output logic [OUT-1:0]          pipe_valid_o,
  output logic [OUT*AXI_DATA_W-1:0] pipe_data_o,
  output logic [OUT*KEEP_LW-1:0]  pipe_len_o,
  output logic [OUT-1:0]          pipe_start_o,
  output logic [OUT-1:0]          pipe_end_o,
  output logic                    err_ovf_o,
  output logic                    err_trunc_o
`ifdef MOLD_MSG_CNT_EN
  , output logic [MSG_CNT_W-1:0]  msg_cnt_o
`endif
);
  localparam int HI_W = 8 * (MOLD_LEN_BYTES - 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_rem_q, len_rem_d;
  logic [HI_W-1:0]    len_hi_q, len_hi_d;
  logic [KEEP_LW-1:0] nbytes, first;
  logic [OUT-1:0]     lane_v_d, lane_s_d, lane_e_d;
  logic [KEEP_LW-1:0] lane_off_d [OUT];
  logic [KEEP_LW-1:0] lane_len_d [OUT];
  logic               ovf_d, trunc_d, active, open;
  logic [7:0]         b;
  logic [LEN_W-1:0]   msg_len;
  int                 nfrag, cur;

  logic [OUT-1:0]            pipe_valid_q, pipe_start_q, pipe_end_q;
  logic [OUT*AXI_DATA_W-1:0] pipe_data_q, align_data;
  logic [OUT*KEEP_LW-1:0]    pipe_len_q, align_len;
  logic                      ovf_q, trunc_q;

  cnt_ones_thermo #(.W(AXI_KEEP_W), .CW(KEEP_LW)) u_keep_cnt (
    .thermo_i (keep_i),
    .cnt_o    (nbytes)
  );

  // Byte-serial scan of one beat; fragments past OUT are tracked but not emitted.
  always_comb begin
    state_d   = state_q;
    len_rem_d = len_rem_q;
    len_hi_d  = len_hi_q;
    lane_v_d  = '0;
    lane_s_d  = '0;
    lane_e_d  = '0;
    for (int k = 0; k < OUT; k++) begin
      lane_off_d[k] = '0;
      lane_len_d[k] = '0;
    end
    ovf_d   = 1'b0;
    trunc_d = 1'b0;
    active  = 1'b0;
    open    = 1'b0;
    first   = '0;
    b       = '0;
    msg_len = '0;
    nfrag   = 0;
    cur     = 0;
    if (valid_i) begin
      if (init_v_i) begin
        trunc_d   = (state_q != ST_IDLE);
        state_d   = ST_LEN_ALIGN;
        len_rem_d = '0;
        len_hi_d  = '0;
        first     = init_off_i;
        active    = 1'b1;
      end else if (state_q != ST_IDLE) begin
        active = 1'b1;
      end
    end
    if (active) begin
      for (int i = 0; i < AXI_KEEP_W; i++) begin
        if (KEEP_LW'(i) >= first && KEEP_LW'(i) < nbytes) begin
          b = data_i[i*8 +: 8];
          case (state_d)
            ST_MSG: begin
              if (!open) begin
                cur   = nfrag;
                nfrag = nfrag + 1;
                open  = 1'b1;
                if (cur >= OUT) ovf_d = 1'b1;
                for (int k = 0; k < OUT; k++)
                  if (k == cur) begin
                    lane_v_d[k]   = 1'b1;
                    lane_off_d[k] = KEEP_LW'(i);
                  end
              end
              for (int k = 0; k < OUT; k++)
                if (k == cur) lane_len_d[k] = lane_len_d[k] + KEEP_LW'(1);
              len_rem_d = len_rem_d - LEN_W'(1);
              if (len_rem_d == '0) begin
                for (int k = 0; k < OUT; k++)
                  if (k == cur) lane_e_d[k] = 1'b1;
                state_d = ST_LEN_ALIGN;
                open    = 1'b0;
              end
            end
            ST_LEN_ALIGN: begin
              len_hi_d = b;
              state_d  = ST_LEN_SPLIT;
            end
            ST_LEN_SPLIT: begin
              msg_len = {len_hi_d, b};
              cur     = nfrag;
              nfrag   = nfrag + 1;
              if (cur >= OUT) ovf_d = 1'b1;
              for (int k = 0; k < OUT; k++)
                if (k == cur) begin
                  lane_v_d[k]   = 1'b1;
                  lane_s_d[k]   = 1'b1;
                  lane_off_d[k] = KEEP_LW'(i + 1);
                end
              if (msg_len == '0) begin
                for (int k = 0; k < OUT; k++)
                  if (k == cur) lane_e_d[k] = 1'b1;
                state_d = ST_LEN_ALIGN;
                open    = 1'b0;
              end else begin
                len_rem_d = msg_len;
                state_d   = ST_MSG;
                open      = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      if (last_i) begin
        if (state_d == ST_MSG || state_d == ST_LEN_SPLIT) begin
          trunc_d = 1'b1;
          for (int k = 0; k < OUT; k++)
            if (nfrag > 0 && k == ((nfrag < OUT) ? nfrag : OUT) - 1) lane_e_d[k] = 1'b1;
        end
        state_d   = ST_IDLE;
        len_rem_d = '0;
        len_hi_d  = '0;
      end
    end
  end

  for (genvar g = 0; g < OUT; g++) begin : g_lane
    msg_frag_align #(.DATA_W(AXI_DATA_W), .KEEP_LW(KEEP_LW)) u_align (
      .data_i (data_i),
      .off_i  (lane_off_d[g]),
      .len_i  (lane_len_d[g]),
      .data_o (align_data[g*AXI_DATA_W +: AXI_DATA_W]),
      .len_o  (align_len[g*KEEP_LW +: KEEP_LW])
    );
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      len_rem_q    <= '0;
      len_hi_q     <= '0;
      pipe_valid_q <= '0;
      pipe_start_q <= '0;
      pipe_end_q   <= '0;
      pipe_data_q  <= '0;
      pipe_len_q   <= '0;
      ovf_q        <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_rem_q    <= len_rem_d;
      len_hi_q     <= len_hi_d;
      pipe_valid_q <= lane_v_d;
      pipe_start_q <= lane_s_d;
      pipe_end_q   <= lane_e_d;
      pipe_data_q  <= align_data;
      pipe_len_q   <= align_len;
      ovf_q        <= ovf_d;
      trunc_q      <= trunc_d;
    end
  end

  assign pipe_valid_o = pipe_valid_q;
  assign pipe_start_o = pipe_start_q;
  assign pipe_end_o   = pipe_end_q;
  assign pipe_data_o  = pipe_data_q;
  assign pipe_len_o   = pipe_len_q;
  assign err_ovf_o    = ovf_q;
  assign err_trunc_o  = trunc_q;

`ifdef MOLD_MSG_CNT_EN
  logic [MSG_CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [MSG_CNT_W:0]   cnt_sum;

  // Counts every lane that closes a message, truncated ones included; saturating.
  always_comb begin
    cnt_sum = (valid_i && init_v_i) ? '0 : {1'b0, msg_cnt_q};
    for (int k = 0; k < OUT; k++) cnt_sum = cnt_sum + (MSG_CNT_W+1)'(lane_e_d[k]);
    msg_cnt_d = cnt_sum[MSG_CNT_W] ? '1 : cnt_sum[MSG_CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!nreset) msg_cnt_q <= '0;
    else         msg_cnt_q <= msg_cnt_d;
  end

  assign msg_cnt_o = msg_cnt_q;
`endif
endmodule
